// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS pipeline slice.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// 32-bit instruction capture register with load and clear, used to park a
// fetched instruction while the pipeline is stalled.
module if_hold_buf
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_data,
  output logic [INSTR_W-1:0] o_data
);

  logic [INSTR_W-1:0] r_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC register, redirect handling and drain of stale
// memory accesses. Define FETCH_BUFFER_EN to add the stall hold buffer (HOLD).
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               PC_Write,
  input  logic               BRANCH_TAKEN,
  input  logic [31:0]        BRANCH_TARGET,
  input  logic               JUMP,
  input  logic [31:0]        JUMP_TARGET,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_INSTR,
  output logic [31:0]        IF_PC,
  output logic [31:0]        IF_PCP4,
  output logic               IF_VALID,
  output logic               IF_FLUSH
);

  fetch_state_t r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_req_addr, w_req_addr_next;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_flush;

  assign w_redirect = BRANCH_TAKEN | JUMP;
  assign w_target   = BRANCH_TAKEN ? BRANCH_TARGET : JUMP_TARGET;

`ifdef FETCH_BUFFER_EN
  logic               w_buf_load;
  logic               w_buf_clear;
  logic [INSTR_W-1:0] w_buf_data;

  if_hold_buf u_hold_buf (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (imem_rdata),
    .o_data  (w_buf_data)
  );
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    imem_req        = 1'b1;
    imem_addr       = r_pc;
    IF_PC           = r_pc;
    IF_VALID        = 1'b0;
    IF_INSTR        = NOP;
    w_flush         = 1'b0;
`ifdef FETCH_BUFFER_EN
    w_buf_load      = 1'b0;
    w_buf_clear     = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        IF_VALID = imem_ready & ~w_redirect;
        if (IF_VALID) IF_INSTR = imem_rdata;
        if (w_redirect) begin
          w_flush   = 1'b1;
          w_pc_next = w_target;
          // The in-flight access cannot be cancelled; remember it and wait it out.
          if (!imem_ready) begin
            w_req_addr_next = r_pc;
            w_state_next    = DRAIN;
          end
        end else if (imem_ready) begin
          if (PC_Write) begin
            w_pc_next = r_pc + 32'd4;
          end
`ifdef FETCH_BUFFER_EN
          else begin
            w_buf_load   = 1'b1;
            w_state_next = HOLD;
          end
`endif
        end
      end
      DRAIN: begin
        imem_addr = r_req_addr;
        if (w_redirect) w_pc_next = w_target;
        if (imem_ready) w_state_next = FETCH;
      end
`ifdef FETCH_BUFFER_EN
      HOLD: begin
        imem_req = 1'b0;
        IF_VALID = ~w_redirect;
        if (IF_VALID) IF_INSTR = w_buf_data;
        if (w_redirect) begin
          w_flush      = 1'b1;
          w_pc_next    = w_target;
          w_buf_clear  = 1'b1;
          w_state_next = FETCH;
        end else if (PC_Write) begin
          w_pc_next    = r_pc + 32'd4;
          w_buf_clear  = 1'b1;
          w_state_next = FETCH;
        end
      end
`endif
      default: w_state_next = FETCH;
    endcase
  end

  assign IF_FLUSH = w_flush & ~reset;
  assign IF_PCP4  = IF_PC + 32'd4;

endmodule
